data_io_wide: RTL and testbench
===============================

DATA_IO_WIDE -- requirements
Module: data_io_wide

Interface
REQ-001 Parameter START_ADDR, default 25'd0, first ioctl_addr of every download.
REQ-002 Parameter DW, default 8, ioctl_dout width; legal values 8 or 16.
REQ-003 Parameter FIFO_DEPTH, default 16, byte FIFO entries; power of two, at least 4.
REQ-004 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 SPI_SCK, SPI_SS2, SPI_DI  in  1 each  IO-controller SPI, asynchronous to clk_sys, oversampled.
REQ-007 ioctl_wait  in  1  core back-pressure; high forbids issuing ioctl_wr.
REQ-008 ioctl_download  out  1  download active.
REQ-009 ioctl_index  out  8  menu index latched at download start.
REQ-010 ioctl_wr  out  1  one-cycle strobe, ioctl_addr/ioctl_dout valid.
REQ-011 ioctl_addr  out  25  address of current word.
REQ-012 ioctl_dout  out  DW  write data.
REQ-013 ioctl_fileext  out  24  file extension; ioctl_filesize  out  32  file size.
REQ-014 overflow  out  1  sticky, a data byte was dropped on a full FIFO.

Function
REQ-015 SPI_SCK, SPI_SS2, SPI_DI each pass a 2-flop synchronizer; SCK rising edge = synced SCK 0->1; clk_sys SHALL be at least 4x SCK rate.
REQ-016 Synced SS2 high: bit counter and frame byte counter cleared, no byte decoded; SS2 may rise mid-byte, partial byte discarded.
REQ-017 Bits MSB first; byte 0 of each frame is the command, later bytes are payload of that command.
REQ-018 Cmd 0x53: payload bit0=1 is START, bit0=0 is END.
REQ-019 Cmd 0x54: every payload byte pushed into the byte FIFO; FIFO full -> byte dropped, overflow set.
REQ-020 Cmd 0x55: payload byte stored in index_reg.
REQ-021 Cmd 0x56: payload bytes 8,9,10 -> ioctl_fileext[23:16],[15:8],[7:0]; bytes 28..31 -> ioctl_filesize little-endian; other bytes ignored.
REQ-022 Unknown commands: payload ignored.
REQ-023 States IDLE, RUN, DRAIN; reset -> IDLE.
REQ-024 START in any state: FIFO flushed, half-word cleared, addr=START_ADDR, ioctl_index=index_reg, overflow=0, ioctl_download=1 next cycle, state RUN.
REQ-025 END in RUN -> DRAIN; END in IDLE or DRAIN ignored.
REQ-026 Assembler pops one byte per cycle when FIFO non-empty and no complete word is pending.
REQ-027 DW=8: each byte is a complete word. DW=16: first byte -> [7:0], second -> [15:8].
REQ-028 Complete word and ioctl_wait low: ioctl_wr=1 for one cycle with ioctl_addr=addr, ioctl_dout=word; addr += DW/8 (25-bit wrap).
REQ-029 ioctl_wait high: word, address, FIFO contents held; no strobe.
REQ-030 DRAIN, FIFO empty, DW=16 half-word pending: word issued with [15:8]=8'h00.
REQ-031 DRAIN, FIFO empty, nothing pending: ioctl_download=0 next cycle, state IDLE.
REQ-032 FIFO push and pop in the same cycle on a full FIFO: pop succeeds, push accepted, no overflow.

Reset
REQ-033 reset high: ioctl_download=0, ioctl_wr=0, ioctl_index=0, ioctl_addr=0, ioctl_dout=0, ioctl_fileext=0, ioctl_filesize=0, overflow=0, FIFO empty, index_reg=0, state IDLE.
REQ-034 reset mid-download: download aborted; no ioctl_wr until a new START.

Verification
REQ-035 DW=8, SCK=clk/8: 0x55 idx 0x03; 0x53 0x01; 0x54 AA BB CC; 0x53 0x00 -> index 3, wr at addr 0,1,2 data AA,BB,CC, download drops after third wr.
REQ-036 DW=16: 0x54 11 22 33, END -> wr addr 0 data 0x2211, wr addr 2 data 0x0033, then download=0.
REQ-037 ioctl_wait high for 100 cycles during a 40-byte burst, FIFO_DEPTH=16 -> exactly 16 bytes written, overflow=1; wait low -> 16 writes in order.
REQ-038 0x56 with 32 bytes, bytes 8-10 "ROM", 28-31 00 10 00 00 -> fileext 0x524F4D, filesize 0x00001000.
REQ-039 START mid-download with 3 bytes queued -> queued bytes discarded, next write at START_ADDR.
REQ-040 SS2 raised after 4 bits of a data byte, then reset mid-burst -> no write of the partial byte; after reset all outputs 0, no writes.

Source files
------------

// File: rtl/data_io_wide.sv
// IO-controller SPI download receiver: decodes command frames, buffers file data
// in a byte FIFO and replays it to the core as DW-wide ioctl writes.
module data_io_wide #(
  parameter logic [24:0] START_ADDR = 25'd0,
  parameter int          DW         = 8,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          SPI_SCK,
  input  logic          SPI_SS2,
  input  logic          SPI_DI,
  input  logic          ioctl_wait,
  output logic          ioctl_download,
  output logic [7:0]    ioctl_index,
  output logic          ioctl_wr,
  output logic [24:0]   ioctl_addr,
  output logic [DW-1:0] ioctl_dout,
  output logic [23:0]   ioctl_fileext,
  output logic [31:0]   ioctl_filesize,
  output logic          overflow
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [24:0] ADDR_STEP = 25'(DW / 8);
  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  RUN       = 2'd1;
  localparam logic [1:0]  DRAIN     = 2'd2;

  logic [1:0]    sck_sync_r, ss_sync_r, di_sync_r;
  logic          sck_prev_r;
  logic          sck_rise_s;
  logic [2:0]    bit_cnt_r;
  logic [6:0]    shift_r;
  logic [7:0]    byte_pos_r;
  logic          rx_valid_r;
  logic [7:0]    rx_data_r, rx_pos_r;
  logic [7:0]    cmd_r, index_reg_r;
  logic          payload_s, start_s, end_s, push_s, pop_s, push_ok_s;
  logic          full_s, empty_s;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic [7:0]    fifo_out_s;
  logic [1:0]    state_r;
  logic [24:0]   addr_r;
  logic [DW-1:0] word_r;
  logic          half_r, pending_r;

  // Two-flop synchronizers; SS2 idles deselected.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sck_sync_r <= 2'b00;
      ss_sync_r  <= 2'b11;
      di_sync_r  <= 2'b00;
      sck_prev_r <= 1'b0;
    end else begin
      sck_sync_r <= {sck_sync_r[0], SPI_SCK};
      ss_sync_r  <= {ss_sync_r[0], SPI_SS2};
      di_sync_r  <= {di_sync_r[0], SPI_DI};
      sck_prev_r <= sck_sync_r[1];
    end
  end

  assign sck_rise_s = sck_sync_r[1] & ~sck_prev_r;

  // Bit shifter; emits one registered byte pulse tagged with its frame position.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bit_cnt_r  <= 3'd0;
      shift_r    <= 7'd0;
      byte_pos_r <= 8'd0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'd0;
      rx_pos_r   <= 8'd0;
    end else begin
      rx_valid_r <= 1'b0;
      if (ss_sync_r[1]) begin
        bit_cnt_r  <= 3'd0;
        byte_pos_r <= 8'd0;
      end else if (sck_rise_s) begin
        shift_r   <= {shift_r[5:0], di_sync_r[1]};
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          rx_valid_r <= 1'b1;
          rx_data_r  <= {shift_r, di_sync_r[1]};
          rx_pos_r   <= byte_pos_r;
          if (byte_pos_r != 8'hFF) byte_pos_r <= byte_pos_r + 8'd1;
        end
      end
    end
  end

  // Command strobes and FIFO handshake.
  always_comb begin
    payload_s = rx_valid_r && (rx_pos_r != 8'd0);
    start_s   = payload_s && (cmd_r == 8'h53) && rx_data_r[0];
    end_s     = payload_s && (cmd_r == 8'h53) && !rx_data_r[0];
    push_s    = payload_s && (cmd_r == 8'h54) && (state_r != IDLE);
    full_s    = (count_r == (AW+1)'(FIFO_DEPTH));
    empty_s   = (count_r == {(AW+1){1'b0}});
    pop_s     = (state_r != IDLE) && !empty_s && !pending_r && !ioctl_wait && !start_s;
    push_ok_s = push_s && (!full_s || pop_s);
  end

  assign fifo_out_s = mem_r[rd_ptr_r];

  // Command register, menu index and file info capture.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cmd_r          <= 8'd0;
      index_reg_r    <= 8'd0;
      ioctl_fileext  <= 24'd0;
      ioctl_filesize <= 32'd0;
    end else begin
      if (rx_valid_r && (rx_pos_r == 8'd0)) cmd_r <= rx_data_r;
      if (payload_s && (cmd_r == 8'h55)) index_reg_r <= rx_data_r;
      if (payload_s && (cmd_r == 8'h56)) begin
        case (rx_pos_r)
          8'd9:    ioctl_fileext[23:16]  <= rx_data_r;
          8'd10:   ioctl_fileext[15:8]   <= rx_data_r;
          8'd11:   ioctl_fileext[7:0]    <= rx_data_r;
          8'd29:   ioctl_filesize[7:0]   <= rx_data_r;
          8'd30:   ioctl_filesize[15:8]  <= rx_data_r;
          8'd31:   ioctl_filesize[23:16] <= rx_data_r;
          8'd32:   ioctl_filesize[31:24] <= rx_data_r;
          default: ioctl_fileext         <= ioctl_fileext;
        endcase
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_r.
  always_ff @(posedge clk_sys) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= rx_data_r;
  end

  // FIFO pointers and occupancy; START flushes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (start_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)     rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Download FSM and word assembler; a held word blocks further pops.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      ioctl_download <= 1'b0;
      ioctl_index    <= 8'd0;
      ioctl_wr       <= 1'b0;
      ioctl_addr     <= 25'd0;
      ioctl_dout     <= {DW{1'b0}};
      overflow       <= 1'b0;
      addr_r         <= 25'd0;
      word_r         <= {DW{1'b0}};
      half_r         <= 1'b0;
      pending_r      <= 1'b0;
    end else begin
      ioctl_wr <= 1'b0;
      if (start_s) begin
        state_r        <= RUN;
        ioctl_download <= 1'b1;
        ioctl_index    <= index_reg_r;
        overflow       <= 1'b0;
        addr_r         <= START_ADDR;
        half_r         <= 1'b0;
        pending_r      <= 1'b0;
      end else begin
        if (push_s && full_s && !pop_s) overflow <= 1'b1;
        if (end_s && (state_r == RUN)) state_r <= DRAIN;
        if (pending_r) begin
          if (!ioctl_wait) begin
            ioctl_wr   <= 1'b1;
            ioctl_addr <= addr_r;
            ioctl_dout <= word_r;
            addr_r     <= addr_r + ADDR_STEP;
            pending_r  <= 1'b0;
          end
        end else if (pop_s) begin
          if (DW == 8) begin
            word_r[7:0] <= fifo_out_s;
            pending_r   <= 1'b1;
          end else if (!half_r) begin
            word_r[7:0] <= fifo_out_s;
            half_r      <= 1'b1;
          end else begin
            word_r[DW-1:DW-8] <= fifo_out_s;
            half_r            <= 1'b0;
            pending_r         <= 1'b1;
          end
        end else if ((state_r == DRAIN) && empty_s) begin
          // An odd trailing byte goes out with a zero upper half.
          if (half_r) begin
            word_r[DW-1:DW-8] <= 8'h00;
            half_r            <= 1'b0;
            pending_r         <= 1'b1;
          end else begin
            ioctl_download <= 1'b0;
            state_r        <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_io_wide.sv
// Bench for data_io_wide: a DW=8 and a DW=16 instance share one SPI bus; writes are
// logged and compared with tables and with a byte-stream reference model.
module tb_data_io_wide;

  localparam logic [24:0] SA8  = 25'd0;
  localparam logic [24:0] SA16 = 25'h0000100;

  logic        clk = 1'b0;
  logic        reset, sck, ss2, di, wait8, wait16;
  logic        dl8, wr8, ovf8, dl16, wr16, ovf16;
  logic [7:0]  idx8, idx16, dout8;
  logic [15:0] dout16;
  logic [24:0] addr8, addr16;
  logic [23:0] ext8, ext16;
  logic [31:0] size8, size16;

  always #5 clk = ~clk;

  data_io_wide #(.START_ADDR(SA8), .DW(8), .FIFO_DEPTH(16)) dut8 (
    .clk_sys(clk), .reset(reset), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
    .ioctl_wait(wait8), .ioctl_download(dl8), .ioctl_index(idx8), .ioctl_wr(wr8),
    .ioctl_addr(addr8), .ioctl_dout(dout8), .ioctl_fileext(ext8),
    .ioctl_filesize(size8), .overflow(ovf8));

  data_io_wide #(.START_ADDR(SA16), .DW(16), .FIFO_DEPTH(16)) dut16 (
    .clk_sys(clk), .reset(reset), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
    .ioctl_wait(wait16), .ioctl_download(dl16), .ioctl_index(idx16), .ioctl_wr(wr16),
    .ioctl_addr(addr16), .ioctl_dout(dout16), .ioctl_fileext(ext16),
    .ioctl_filesize(size16), .overflow(ovf16));

  typedef struct { logic [24:0] a; logic [15:0] d; } wr_t;
  typedef struct { logic [7:0] idx; int n; logic [0:3][7:0] b; logic [15:0] w0; logic [15:0] w1; } dl_vec_t;
  typedef struct { logic [0:2][7:0] ext; logic [0:3][7:0] sz; logic [23:0] e_ext; logic [31:0] e_size; } fi_vec_t;

  wr_t        log8[$], log16[$];
  logic [7:0] pl[$];
  logic [7:0] exp_bytes[$];
  bit         rand_wait = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  dl_vec_t    dv[3];
  fi_vec_t    fv[2];

  always @(negedge clk) begin
    if (wr8 === 1'b1)  log8.push_back('{a: addr8, d: {8'h00, dout8}});
    if (wr16 === 1'b1) log16.push_back('{a: addr16, d: dout16});
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_wait) begin
        wait8  = ($urandom_range(0, 3) == 0);
        wait16 = ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nb);
    for (int i = 7; i > 7 - nb; i--) begin
      @(negedge clk); di = b[i];
      repeat (4) @(negedge clk); sck = 1'b1;
      repeat (4) @(negedge clk); sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] cmd);
    ss2 = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(cmd, 8);
    foreach (pl[i]) spi_bits(pl[i], 8);
    repeat (4) @(negedge clk);
    ss2 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic start_dl();
    pl = '{8'h01}; frame(8'h53);
  endtask

  task automatic end_dl();
    pl = '{8'h00}; frame(8'h53);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((dl8 !== 1'b0 || dl16 !== 1'b0) && t < 5000) begin
      @(negedge clk); t++;
    end
    chk({tag, "_download_end"}, {62'd0, dl8, dl16}, 64'd0);
  endtask

  // Expected writes follow from the byte stream alone: one per byte, or LE pairs.
  task automatic check_writes(input string tag);
    int n16;
    logic [7:0] hi;
    chk({tag, "_n8"}, log8.size(), exp_bytes.size());
    for (int i = 0; i < log8.size() && i < exp_bytes.size(); i++) begin
      chk({tag, "_a8"}, log8[i].a, SA8 + 25'(i));
      chk({tag, "_d8"}, log8[i].d, {8'h00, exp_bytes[i]});
    end
    n16 = (exp_bytes.size() + 1) / 2;
    chk({tag, "_n16"}, log16.size(), n16);
    for (int k = 0; k < log16.size() && k < n16; k++) begin
      hi = (2*k + 1 < exp_bytes.size()) ? exp_bytes[2*k + 1] : 8'h00;
      chk({tag, "_a16"}, log16[k].a, SA16 + 25'(2*k));
      chk({tag, "_d16"}, log16[k].d, {hi, exp_bytes[2*k]});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dl"},   {dl8, dl16}, 2'b00);
    chk({tag, "_wr"},   {wr8, wr16}, 2'b00);
    chk({tag, "_idx"},  {idx8, idx16}, 16'd0);
    chk({tag, "_addr"}, {addr8, addr16}, 50'd0);
    chk({tag, "_dout"}, {dout8, dout16}, 24'd0);
    chk({tag, "_ext"},  {ext8, ext16}, 48'd0);
    chk({tag, "_size"}, {size8, size16}, 64'd0);
    chk({tag, "_ovf"},  {ovf8, ovf16}, 2'b00);
  endtask

  initial begin
    int nf, nb;
    logic [7:0] b;
    reset = 1'b1; sck = 1'b0; ss2 = 1'b1; di = 1'b0; wait8 = 1'b0; wait16 = 1'b0;

    dv[0] = '{idx: 8'h03, n: 3, b: {8'hAA, 8'hBB, 8'hCC, 8'h00}, w0: 16'hBBAA, w1: 16'h00CC};
    dv[1] = '{idx: 8'h07, n: 3, b: {8'h11, 8'h22, 8'h33, 8'h00}, w0: 16'h2211, w1: 16'h0033};
    dv[2] = '{idx: 8'hA5, n: 4, b: {8'h01, 8'h02, 8'h03, 8'h04}, w0: 16'h0201, w1: 16'h0403};
    fv[0] = '{ext: {8'h52, 8'h4F, 8'h4D}, sz: {8'h00, 8'h10, 8'h00, 8'h00}, e_ext: 24'h524F4D, e_size: 32'h00001000};
    fv[1] = '{ext: {8'h42, 8'h49, 8'h4E}, sz: {8'h78, 8'h56, 8'h34, 8'h12}, e_ext: 24'h42494E, e_size: 32'h12345678};

    repeat (5) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Basic downloads with hand-computed DW=16 words.
    for (int v = 0; v < 3; v++) begin
      log8.delete(); log16.delete();
      pl = '{dv[v].idx}; frame(8'h55);
      start_dl();
      pl.delete();
      for (int i = 0; i < dv[v].n; i++) pl.push_back(dv[v].b[i]);
      frame(8'h54);
      end_dl();
      wait_idle("tbl");
      chk("tbl_index", {idx8, idx16}, {dv[v].idx, dv[v].idx});
      chk("tbl_n8", log8.size(), dv[v].n);
      for (int i = 0; i < log8.size() && i < dv[v].n; i++) begin
        chk("tbl_a8", log8[i].a, 25'(i));
        chk("tbl_d8", log8[i].d, {8'h00, dv[v].b[i]});
      end
      chk("tbl_n16", log16.size(), 2);
      if (log16.size() >= 2) begin
        chk("tbl_w0", {log16[0].a, log16[0].d}, {SA16, dv[v].w0});
        chk("tbl_w1", {log16[1].a, log16[1].d}, {SA16 + 25'd2, dv[v].w1});
      end
    end

    // File extension / size capture from a 32-byte info frame.
    for (int v = 0; v < 2; v++) begin
      pl.delete();
      for (int i = 0; i < 32; i++) pl.push_back(8'(i) ^ 8'h5A);
      for (int i = 0; i < 3; i++) pl[8 + i] = fv[v].ext[i];
      for (int i = 0; i < 4; i++) pl[28 + i] = fv[v].sz[i];
      frame(8'h56);
      chk("fileext", {ext8, ext16}, {fv[v].e_ext, fv[v].e_ext});
      chk("filesize", {size8, size16}, {fv[v].e_size, fv[v].e_size});
    end

    // Randomized downloads under random back-pressure.
    for (int r = 0; r < 4; r++) begin
      log8.delete(); log16.delete(); exp_bytes.delete();
      b = 8'($urandom_range(0, 255));
      pl = '{b}; frame(8'h55);
      rand_wait = 1'b1;
      start_dl();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        pl.delete();
        nb = $urandom_range(1, 8);
        for (int i = 0; i < nb; i++) begin
          pl.push_back(8'($urandom_range(0, 255)));
          exp_bytes.push_back(pl[i]);
        end
        frame(8'h54);
      end
      end_dl();
      wait_idle("rnd");
      rand_wait = 1'b0;
      @(negedge clk); wait8 = 1'b0; wait16 = 1'b0;
      chk("rnd_index", {idx8, idx16}, {b, b});
      check_writes("rnd");
    end

    // Held back-pressure over a 40-byte burst: only a FIFO's worth survives.
    log8.delete(); log16.delete(); exp_bytes.delete();
    wait8 = 1'b1; wait16 = 1'b1;
    start_dl();
    pl.delete();
    for (int i = 0; i < 40; i++) pl.push_back(8'(i * 7 + 3));
    frame(8'h54);
    chk("hold_no_wr", log8.size() + log16.size(), 0);
    chk("hold_ovf", {ovf8, ovf16}, 2'b11);
    wait8 = 1'b0; wait16 = 1'b0;
    end_dl();
    wait_idle("hold");
    for (int i = 0; i < 16; i++) exp_bytes.push_back(8'(i * 7 + 3));
    check_writes("hold");

    // Restart with bytes still queued: queue discarded, address restarts.
    log8.delete(); log16.delete();
    wait8 = 1'b1; wait16 = 1'b1;
    start_dl();
    chk("restart_ovf_clr", {ovf8, ovf16}, 2'b00);
    pl = '{8'hF1, 8'hF2, 8'hF3}; frame(8'h54);
    start_dl();
    wait8 = 1'b0; wait16 = 1'b0;
    pl = '{8'hE1, 8'hE2}; frame(8'h54);
    end_dl();
    wait_idle("restart");
    exp_bytes = '{8'hE1, 8'hE2};
    check_writes("restart");

    // Partial byte dropped by SS2, then reset in the middle of a burst.
    log8.delete(); log16.delete();
    start_dl();
    ss2 = 1'b0; repeat (4) @(negedge clk);
    spi_bits(8'h54, 8); spi_bits(8'hC1, 8); spi_bits(8'hC2, 4);
    repeat (4) @(negedge clk); ss2 = 1'b1; repeat (8) @(negedge clk);
    pl = '{8'hD1, 8'hD2}; frame(8'h54);
    ss2 = 1'b0; repeat (4) @(negedge clk);
    spi_bits(8'h54, 8); spi_bits(8'hE5, 8);
    repeat (20) @(negedge clk);
    reset = 1'b1; repeat (3) @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    spi_bits(8'hE6, 8); spi_bits(8'hE7, 8);
    repeat (4) @(negedge clk); ss2 = 1'b1;
    repeat (100) @(negedge clk);
    check_zero("postreset");
    exp_bytes = '{8'hC1, 8'hD1, 8'hD2, 8'hE5};
    check_writes("partial");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
